// File: rtl/uart_line_buffer_pkg.sv
// Shared constants and FSM encoding for the UART line buffer.
package uart_line_buffer_pkg;

   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   typedef enum logic [2:0] {
      S_CAPTURE  = 3'd0,
      S_POP_WAIT = 3'd1,
      S_FETCH    = 3'd2,
      S_PUSH     = 3'd3,
      S_SEND_LF  = 3'd4,
      S_DONE     = 3'd5
   } state_t;

endpackage

// File: rtl/uart_line_buffer_ram.sv
// Simple dual-port line store: one synchronous write port, one synchronous
// read port, no reset (contents survive reset by design).
module uart_line_buffer_ram #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clock,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]        i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [7:0]        o_rd_data
);

   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rd_data;

   // Write port.
   always_ff @(posedge clock) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   // Read port, one cycle of latency; reads every cycle so data holds while the address holds.
   always_ff @(posedge clock) begin
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_line_buffer.sv
// Line-oriented store between uart_rx and uart_tx: captures one line with
// backspace editing, then replays it to the transmitter on request.
//
// state     | meaning
// ----------+----------------------------------------------------------
// CAPTURE   | idle/capturing; pops rx chars, or starts a pending send
// POP_WAIT  | one-cycle gap so rx_data_present reflects the last pop
// FETCH     | RAM read of rd_ptr in flight
// PUSH      | hand RAM byte to uart_tx when it has room
// SEND_LF   | hand trailing LF to uart_tx when it has room
// DONE      | clear the line and drop busy
module uart_line_buffer
   import uart_line_buffer_pkg::*;
#(
   parameter int         DEPTH     = 64,
   parameter int         ADDR_W    = 6,
   parameter logic [7:0] EOL_CHAR  = ASCII_CR,
   parameter bit         APPEND_LF = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_data_present,
   output logic              o_read_from_uart,
   output logic [7:0]        o_tx_data,
   output logic              o_write_to_uart,
   input  logic              i_tx_full,
   input  logic              i_send,
   output logic [ADDR_W:0]   o_line_length,
   output logic              o_line_ready,
   output logic              o_overflow,
   output logic              o_busy
);

   localparam int               CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] w_rd_ptr_inc;
   logic             r_line_ready;
   logic             r_overflow;
   logic             r_busy;
   logic             r_send_pending;
   logic [7:0]       r_tx_data;
   logic             r_write;
   logic             w_pop;
   logic             w_start;
   logic             w_start_empty;
   logic             w_push_char;
   logic             w_push_lf;
   logic             w_done;
   logic             w_is_bs;
   logic             w_full;
   logic             w_wr_en;
   logic [7:0]       w_rd_data;

   assign w_rd_ptr_inc = r_rd_ptr + ONE;
   assign w_is_bs      = (i_rx_data == ASCII_BS);
   assign w_full       = (r_count == FULL_CNT);
   assign w_wr_en      = w_pop && !w_is_bs && !w_full;

   uart_line_buffer_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_line_ram (
      .clock     (clock),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_count[ADDR_W-1:0]),
      .i_wr_data (i_rx_data),
      .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
      .o_rd_data (w_rd_data)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_CAPTURE;
      else       r_state <= w_state_next;
   end

   // Next-state and per-cycle control strobes; a pop always wins over starting a send.
   always_comb begin
      w_state_next  = r_state;
      w_pop         = 1'b0;
      w_start       = 1'b0;
      w_start_empty = 1'b0;
      w_push_char   = 1'b0;
      w_push_lf     = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         S_CAPTURE: begin
            if (i_rx_data_present && !r_line_ready) begin
               w_pop        = 1'b1;
               w_state_next = S_POP_WAIT;
            end else if (r_send_pending) begin
               if (r_count == '0) begin
                  w_start_empty = 1'b1;
                  w_state_next  = APPEND_LF ? S_SEND_LF : S_CAPTURE;
               end else begin
                  w_start      = 1'b1;
                  w_state_next = S_FETCH;
               end
            end
         end
         S_POP_WAIT: w_state_next = S_CAPTURE;
         S_FETCH:    w_state_next = S_PUSH;
         S_PUSH: begin
            if (!i_tx_full) begin
               w_push_char = 1'b1;
               if (w_rd_ptr_inc == r_count) w_state_next = APPEND_LF ? S_SEND_LF : S_DONE;
               else                         w_state_next = S_FETCH;
            end
         end
         S_SEND_LF: begin
            if (!i_tx_full) begin
               w_push_lf    = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_state_next = S_CAPTURE;
         end
         default: w_state_next = S_CAPTURE;
      endcase
   end

   // Line count, flags, read pointer and transmit byte.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count        <= '0;
         r_rd_ptr       <= '0;
         r_line_ready   <= 1'b0;
         r_overflow     <= 1'b0;
         r_busy         <= 1'b0;
         r_send_pending <= 1'b0;
         r_tx_data      <= '0;
         r_write        <= 1'b0;
      end else begin
         r_send_pending <= i_send | (r_send_pending & ~(w_start | w_start_empty));
         r_write        <= w_push_char | w_push_lf;
         if (w_pop) begin
            if (w_is_bs) begin
               if (r_count != '0) r_count <= r_count - ONE;
            end else if (w_full) begin
               r_overflow <= 1'b1;
            end else begin
               r_count <= r_count + ONE;
               if (i_rx_data == EOL_CHAR) r_line_ready <= 1'b1;
            end
         end
         if (w_start) begin
            r_busy   <= 1'b1;
            r_rd_ptr <= '0;
         end
         if (w_start_empty && APPEND_LF) r_busy <= 1'b1;
         if (w_push_char) begin
            r_tx_data <= w_rd_data;
            r_rd_ptr  <= w_rd_ptr_inc;
         end
         if (w_push_lf) r_tx_data <= ASCII_LF;
         if (w_done) begin
            r_count      <= '0;
            r_line_ready <= 1'b0;
            r_busy       <= 1'b0;
         end
      end
   end

   // Strobes are gated by reset so they drop in the cycle reset is raised.
   assign o_read_from_uart = w_pop & ~reset;
   assign o_write_to_uart  = r_write & ~reset;
   assign o_tx_data        = r_tx_data;
   assign o_line_length    = r_count;
   assign o_line_ready     = r_line_ready;
   assign o_overflow       = r_overflow;
   assign o_busy           = r_busy;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: rx FIFO model, tx scoreboard, table of edit
// vectors plus hand-written multi-cycle sequences.
module tb_uart_line_buffer;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clock = 1'b0;
   logic              reset;
   logic [7:0]        i_rx_data;
   logic              i_rx_data_present;
   logic              o_read_from_uart;
   logic [7:0]        o_tx_data;
   logic              o_write_to_uart;
   logic              i_tx_full;
   logic              i_send;
   logic [ADDR_W:0]   o_line_length;
   logic              o_line_ready;
   logic              o_overflow;
   logic              o_busy;

   always #5 clock = ~clock;

   uart_line_buffer #(
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .EOL_CHAR  (8'h0D),
      .APPEND_LF (1'b1)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .i_rx_data         (i_rx_data),
      .i_rx_data_present (i_rx_data_present),
      .o_read_from_uart  (o_read_from_uart),
      .o_tx_data         (o_tx_data),
      .o_write_to_uart   (o_write_to_uart),
      .i_tx_full         (i_tx_full),
      .i_send            (i_send),
      .o_line_length     (o_line_length),
      .o_line_ready      (o_line_ready),
      .o_overflow        (o_overflow),
      .o_busy            (o_busy)
   );

   typedef struct {
      logic [7:0] rx  [8];
      int         n_rx;
      logic [7:0] exp [8];
      int         n_exp;
   } vec_t;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] rx_q [$];
   logic [7:0] sb_q [$];
   int         pop_cycles [$];
   int         n_writes = 0;
   int         cycle    = 0;
   bit         pop_seen = 1'b0;
   bit         prev_pop = 1'b0;
   vec_t       vecs [5];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_rx();
      if (rx_q.size() > 0) begin
         i_rx_data         = rx_q[0];
         i_rx_data_present = 1'b1;
      end else begin
         i_rx_data         = 8'h00;
         i_rx_data_present = 1'b0;
      end
   endtask

   // One clock: monitor at negedge, rx FIFO pops just after posedge, inputs settle at +2.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         cycle++;
         pop_seen = o_read_from_uart;
         if (o_read_from_uart) begin
            pop_cycles.push_back(cycle);
            check("no_consecutive_pop", prev_pop, 0);
         end
         prev_pop = o_read_from_uart;
         if (o_write_to_uart) begin
            n_writes++;
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_write: got 0x%0h, expected no write", o_tx_data);
            end else begin
               check("tx_byte", o_tx_data, sb_q.pop_front());
            end
         end
         @(posedge clock);
         #1;
         if (pop_seen && rx_q.size() > 0) void'(rx_q.pop_front());
         pop_seen = 1'b0;
         drive_rx();
         #1;
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      i_send    = 1'b0;
      i_tx_full = 1'b0;
      rx_q.delete();
      sb_q.delete();
      drive_rx();
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic pulse_send();
      i_send = 1'b1;
      tick(1);
      i_send = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int budget);
      int k = 0;
      while (!o_line_ready && k < budget) begin
         tick(1);
         k++;
      end
      check(name, o_line_ready, 1);
   endtask

   task automatic wait_rx_empty(input string name, input int budget);
      int k = 0;
      while (rx_q.size() > 0 && k < budget) begin
         tick(1);
         k++;
      end
      tick(2);
      check(name, rx_q.size(), 0);
   endtask

   task automatic wait_writes(input string name, input int target, input int budget);
      int k = 0;
      while (n_writes < target && k < budget) begin
         tick(1);
         k++;
      end
      check(name, (n_writes >= target) ? 1 : 0, 1);
   endtask

   task automatic wait_send_done(input string name, input int budget);
      int k = 0;
      bit saw_busy = 1'b0;
      while ((sb_q.size() > 0 || o_busy) && k < budget) begin
         if (o_busy) saw_busy = 1'b1;
         tick(1);
         k++;
      end
      check({name, "_sb_drained"}, sb_q.size(), 0);
      check({name, "_busy_seen"}, saw_busy, 1);
      check({name, "_busy_low"}, o_busy, 0);
      check({name, "_len_cleared"}, o_line_length, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{'{8'h48, 8'h69, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3,
                  '{8'h48, 8'h69, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3};
      vecs[1] = '{'{8'h41, 8'h58, 8'h08, 8'h42, 8'h0D, 8'h00, 8'h00, 8'h00}, 5,
                  '{8'h41, 8'h42, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3};
      vecs[2] = '{'{8'h08, 8'h41, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3,
                  '{8'h41, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2};
      vecs[3] = '{'{8'h41, 8'h08, 8'h08, 8'h08, 8'h0D, 8'h00, 8'h00, 8'h00}, 5,
                  '{8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1};
      vecs[4] = '{'{8'h31, 8'h32, 8'h08, 8'h33, 8'h34, 8'h08, 8'h35, 8'h0D}, 8,
                  '{8'h31, 8'h33, 8'h35, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00}, 4};

      // Reset state.
      reset     = 1'b1;
      i_send    = 1'b0;
      i_tx_full = 1'b0;
      drive_rx();
      tick(2);
      check("rst_read", o_read_from_uart, 0);
      check("rst_write", o_write_to_uart, 0);
      check("rst_len", o_line_length, 0);
      check("rst_ready", o_line_ready, 0);
      check("rst_ovf", o_overflow, 0);
      check("rst_busy", o_busy, 0);
      check("rst_txdata", o_tx_data, 0);
      reset = 1'b0;
      tick(1);

      // "AB\r" then 'C': three pops two cycles apart, 'C' stays queued.
      pop_cycles.delete();
      rx_q.push_back(8'h41); rx_q.push_back(8'h42);
      rx_q.push_back(8'h0D); rx_q.push_back(8'h43);
      wait_ready("t1_ready", 50);
      tick(10);
      check("t1_pop_count", pop_cycles.size(), 3);
      if (pop_cycles.size() == 3) begin
         check("t1_gap1", pop_cycles[1] - pop_cycles[0], 2);
         check("t1_gap2", pop_cycles[2] - pop_cycles[1], 2);
      end
      check("t1_len", o_line_length, 3);
      check("t1_ready_hold", o_line_ready, 1);
      check("t1_c_queued", rx_q.size(), 1);

      // Replay with LF, then the held 'C' is captured.
      sb_q.push_back(8'h41); sb_q.push_back(8'h42);
      sb_q.push_back(8'h0D); sb_q.push_back(8'h0A);
      pulse_send();
      wait_send_done("t2", 200);
      check("t2_ready_clr", o_line_ready, 0);
      tick(4);
      check("t2_c_popped", rx_q.size(), 0);
      check("t2_c_len", o_line_length, 1);

      // Table of edit vectors: capture, compare length, replay.
      for (int v = 0; v < 5; v++) begin
         do_reset();
         for (int i = 0; i < vecs[v].n_rx; i++) rx_q.push_back(vecs[v].rx[i]);
         wait_ready($sformatf("vec%0d_ready", v), 100);
         check($sformatf("vec%0d_len", v), o_line_length, vecs[v].n_exp);
         check($sformatf("vec%0d_ovf", v), o_overflow, 0);
         for (int i = 0; i < vecs[v].n_exp; i++) sb_q.push_back(vecs[v].exp[i]);
         sb_q.push_back(8'h0A);
         pulse_send();
         wait_send_done($sformatf("vec%0d", v), 200);
      end

      // tx_full held for 20 cycles mid-line.
      do_reset();
      foreach (vecs[0].rx[i]) if (i < 0) rx_q.push_back(8'h00);
      rx_q.push_back(8'h48); rx_q.push_back(8'h45); rx_q.push_back(8'h4C);
      rx_q.push_back(8'h4C); rx_q.push_back(8'h4F); rx_q.push_back(8'h0D);
      wait_ready("t3_ready", 100);
      sb_q.push_back(8'h48); sb_q.push_back(8'h45); sb_q.push_back(8'h4C);
      sb_q.push_back(8'h4C); sb_q.push_back(8'h4F); sb_q.push_back(8'h0D);
      sb_q.push_back(8'h0A);
      begin
         int base;
         base = n_writes;
         pulse_send();
         wait_writes("t3_first_writes", base + 2, 50);
         i_tx_full = 1'b1;
         tick(1);
         base = n_writes;
         tick(20);
         check("t3_no_write_while_full", n_writes - base, 0);
         check("t3_busy_while_full", o_busy, 1);
         i_tx_full = 1'b0;
      end
      wait_send_done("t3", 200);

      // Send while busy queues a second, empty-line send (LF only).
      do_reset();
      rx_q.push_back(8'h5A); rx_q.push_back(8'h0D);
      wait_ready("t7_ready", 50);
      sb_q.push_back(8'h5A); sb_q.push_back(8'h0D);
      sb_q.push_back(8'h0A); sb_q.push_back(8'h0A);
      pulse_send();
      tick(2);
      check("t7_busy", o_busy, 1);
      pulse_send();
      wait_send_done("t7", 200);

      // Send with an empty line emits LF only.
      do_reset();
      sb_q.push_back(8'h0A);
      pulse_send();
      wait_send_done("t8", 50);

      // DEPTH+2 characters: saturate at DEPTH, sticky overflow, all popped.
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) rx_q.push_back(8'(8'h41 + (i % 26)));
      wait_rx_empty("t5_all_popped", 400);
      check("t5_len", o_line_length, DEPTH);
      check("t5_ovf", o_overflow, 1);
      check("t5_ready", o_line_ready, 0);
      for (int i = 0; i < DEPTH; i++) sb_q.push_back(8'(8'h41 + (i % 26)));
      sb_q.push_back(8'h0A);
      pulse_send();
      wait_send_done("t5", 1000);
      check("t5_ovf_sticky", o_overflow, 1);

      // Reset while stalled in PUSH, then a clean capture/replay.
      do_reset();
      rx_q.push_back(8'h41); rx_q.push_back(8'h42); rx_q.push_back(8'h43);
      rx_q.push_back(8'h44); rx_q.push_back(8'h45); rx_q.push_back(8'h46);
      rx_q.push_back(8'h0D);
      wait_ready("t6_ready", 100);
      sb_q.push_back(8'h41); sb_q.push_back(8'h42); sb_q.push_back(8'h43);
      begin
         int base;
         base = n_writes;
         pulse_send();
         wait_writes("t6_writes", base + 2, 50);
      end
      i_tx_full = 1'b1;
      tick(3);
      check("t6_busy_pre", o_busy, 1);
      reset = 1'b1;
      sb_q.delete();
      #1;
      check("t6_write_same_cycle", o_write_to_uart, 0);
      tick(1);
      check("t6_write", o_write_to_uart, 0);
      check("t6_busy", o_busy, 0);
      check("t6_len", o_line_length, 0);
      check("t6_ready", o_line_ready, 0);
      reset     = 1'b0;
      i_tx_full = 1'b0;
      tick(1);
      rx_q.push_back(8'h4F); rx_q.push_back(8'h4B); rx_q.push_back(8'h0D);
      wait_ready("t6_post_ready", 50);
      check("t6_post_len", o_line_length, 3);
      sb_q.push_back(8'h4F); sb_q.push_back(8'h4B);
      sb_q.push_back(8'h0D); sb_q.push_back(8'h0A);
      pulse_send();
      wait_send_done("t6_post", 200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
